// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among N_REQ byte requesters.
// The granted byte is captured and held on tx_data. tx_start is driven until the
// transmitter's ready line, synchronized into clk, is seen to fall.
// Optional build macro UART_ARB_LOCK_EN adds req_lock, which gives exclusive access.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [N_REQ-1:0]     req_lock,
`endif
  output logic [N_REQ-1:0]     ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [ID_W-1:0]        rr_ptr_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rdy_s;
  logic [7:0]             data_arr [N_REQ];
  logic [N_REQ-1:0]       eligible;
  logic                   win_found;
  logic [ID_W-1:0]        win_idx;

  // Unpack the flat request data bus into one byte per requester.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[8*gi +: 8];
    end
  endgenerate

`ifdef UART_ARB_LOCK_EN
  logic            lock_active_reg;
  logic [ID_W-1:0] lock_id_reg;
  logic            lock_hold;

  // The lock keeps holding only while the owner still asserts its req_lock bit.
  assign lock_hold = lock_active_reg && req_lock[lock_id_reg];

  // While locked, only the owner's request can win.
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lock_mask
      assign eligible[gi] = req[gi] && (!lock_hold || (lock_id_reg == ID_W'(gi)));
    end
  endgenerate
`else
  assign eligible = req;
`endif

  // tx_ready comes from the tx_clk domain; only the last flop's output is used.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], tx_ready};
    end
  end

  assign rdy_s = sync_reg[SYNC_STAGES-1];

  // Round-robin search: first eligible requester after the last winner.
  always_comb begin
    logic [ID_W-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr_reg) + k) % N_REQ);
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Grant/issue/busy sequencer with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      tx_start        <= 1'b0;
      tx_data         <= 8'h00;
      ack             <= '0;
      grant_id        <= '0;
      busy            <= 1'b0;
      rr_ptr_reg      <= ID_W'(N_REQ - 1);
`ifdef UART_ARB_LOCK_EN
      lock_active_reg <= 1'b0;
      lock_id_reg     <= '0;
`endif
    end else begin
      ack <= '0;
      case (state_reg)
        IDLE: begin
`ifdef UART_ARB_LOCK_EN
          if (lock_active_reg && !req_lock[lock_id_reg]) begin
            lock_active_reg <= 1'b0;
          end
`endif
          if (win_found && rdy_s) begin
            tx_data    <= data_arr[win_idx];
            grant_id   <= win_idx;
            rr_ptr_reg <= win_idx;
            ack        <= N_REQ'(1) << win_idx;
            tx_start   <= 1'b1;
            busy       <= 1'b1;
            state_reg  <= ISSUE;
`ifdef UART_ARB_LOCK_EN
            lock_active_reg <= req_lock[win_idx];
            lock_id_reg     <= win_idx;
`endif
          end
        end
        ISSUE: begin
          // The transmitter has accepted start once its ready falls.
          if (!rdy_s) begin
            tx_start  <= 1'b0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (rdy_s) begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          tx_start  <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a transaction-level model of the arbiter plus a
// simple uart_tx ready model, with directed scenarios followed by random traffic.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int S  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [IW-1:0]  grant_id;
  logic           busy;
`ifdef UART_ARB_LOCK_EN
  logic [N-1:0]   req_lock = '0;
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .ID_W(IW), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
`ifdef UART_ARB_LOCK_EN
    .req_lock (req_lock),
`endif
    .ack      (ack),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .grant_id (grant_id),
    .busy     (busy)
  );

  int total = 0;
  int bad   = 0;

  // Model of the arbiter: a transfer is "open" from grant until ready is seen
  // low and then high again; ready is seen S clocks late.
  bit         m_open     = 0;
  bit         m_low_seen = 0;
  int         m_last     = N - 1;
  logic [7:0] m_data     = 8'h00;
  bit         m_start    = 0;
  logic [N-1:0] m_ack    = '0;
  int         m_gid      = 0;
  bit         rq[$];

  // Transmitter model state.
  int tx_ph     = 0;
  int tx_cnt    = 0;
  int next_fall = -1;

  int         dut_order[$];
  logic [7:0] dut_bytes[$];
  int         exp_order[5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp_bytes[5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return 0;
  endfunction

  task automatic model_edge();
    bit rs;
    int w;
    if (rst) begin
      m_open = 0; m_start = 0; m_data = 8'h00; m_ack = '0; m_gid = 0; m_last = N - 1;
      rq = {};
      repeat (S) rq.push_back(1'b1);
    end else begin
      rs = rq.pop_front();
      rq.push_back(tx_ready);
      m_ack = '0;
      if (!m_open) begin
        if (rs && req != '0) begin
          w = pick(req, m_last);
          m_last = w; m_gid = w; m_data = req_data[8*w +: 8];
          m_ack = N'(1) << w; m_start = 1; m_open = 1; m_low_seen = 0;
        end
      end else if (!m_low_seen) begin
        if (!rs) begin m_low_seen = 1; m_start = 0; end
      end else if (rs) begin
        m_open = 0;
      end
    end
  endtask

  task automatic tx_reset();
    tx_ready = 1'b1;
    tx_ph    = 0;
    tx_cnt   = 0;
  endtask

  task automatic tx_model();
    int d;
    case (tx_ph)
      0: if (tx_start && !rst) begin
           d = (next_fall >= 0) ? next_fall : int'($urandom_range(0, 3));
           next_fall = -1;
           if (d == 0) begin tx_ready = 1'b0; tx_cnt = $urandom_range(4, 12); tx_ph = 2; end
           else begin tx_cnt = d; tx_ph = 1; end
         end
      1: begin
           tx_cnt--;
           if (tx_cnt == 0) begin tx_ready = 1'b0; tx_cnt = $urandom_range(4, 12); tx_ph = 2; end
         end
      default: begin
           tx_cnt--;
           if (tx_cnt == 0) begin tx_ready = 1'b1; tx_ph = 0; end
         end
    endcase
  endtask

  // One clock: update model with pre-edge inputs, compare after the edge, step the transmitter.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("ack", int'(ack), int'(m_ack));
    check("ack_onehot", int'($countones(ack) <= 1), 1);
    check("tx_start", int'(tx_start), int'(m_start));
    check("tx_data", int'(tx_data), int'(m_data));
    check("grant_id", int'(grant_id), m_gid);
    check("busy", int'(busy), int'(m_open));
    tx_model();
  endtask

  task automatic wait_ack(input string name, input int maxc);
    int n = 0;
    step();
    while (ack == '0 && n < maxc) begin step(); n++; end
    if (ack == '0) timeout(name);
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n = 0;
    while ((busy || tx_ph != 0) && n < maxc) begin step(); n++; end
    if (busy || tx_ph != 0) timeout(name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int start_cycles, extra_acks, gid_bad;
    rst = 1'b1; req = '0; req_data = '0; tx_ready = 1'b1;
    repeat (S) rq.push_back(1'b1);

    // Reset values.
    do_reset();
    step();
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_tx_data", int'(tx_data), 8'h00);
    check("rst_ack", int'(ack), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_busy", int'(busy), 0);

    // Single request, then data changes after ack must not reach tx_data.
    req = 4'b0001; req_data[7:0] = 8'hA5;
    wait_ack("single_ack", 20);
    check("single_ack_val", int'(ack), 4'b0001);
    check("single_tx_data", int'(tx_data), 8'hA5);
    check("single_tx_start", int'(tx_start), 1);
    req = '0; req_data[7:0] = 8'hFF;
    n = 0;
    while (busy && n < 100) begin
      step();
      check("hold_data", int'(tx_data), 8'hA5);
      n++;
    end
    if (busy) timeout("single_idle");
    check("hold_after_idle", int'(tx_data), 8'hA5);
    wait_idle("single_tx_idle", 100);

    // All four requesting from reset; requester 0 holds continuously.
    do_reset();
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    req = 4'b1111;
    n = 0;
    while (dut_order.size() < 5 && n < 400) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          dut_order.push_back(i);
          dut_bytes.push_back(tx_data);
          if (i != 0) req[i] = 1'b0;
        end
      end
      n++;
    end
    req = '0;
    if (dut_order.size() < 5) timeout("rr_order");
    else begin
      for (int k = 0; k < 5; k++) begin
        check("rr_order", dut_order[k], exp_order[k]);
        check("rr_byte", int'(dut_bytes[k]), int'(exp_bytes[k]));
      end
    end
    wait_idle("rr_idle", 100);

    // Slow ready fall: start must stay up, with no extra ack or grant change.
    next_fall = 50;
    req = 4'b0010; req_data[15:8] = 8'h5C;
    wait_ack("slow_ack", 20);
    req = '0;
    start_cycles = 0; extra_acks = 0; gid_bad = 0; n = 0;
    while (tx_start && n < 200) begin
      step();
      if (tx_start) start_cycles++;
      if (ack != '0) extra_acks++;
      if (grant_id != 2'd1) gid_bad++;
      n++;
    end
    check("slow_start_ge50", int'(start_cycles >= 50), 1);
    check("slow_extra_acks", extra_acks, 0);
    check("slow_gid_stable", gid_bad, 0);
    wait_idle("slow_idle", 100);

    // Reset while in BUSY.
    req = 4'b0100; req_data[23:16] = 8'h77;
    wait_ack("busy_ack", 20);
    req = '0;
    n = 0;
    while (!(busy && !tx_start) && n < 50) begin step(); n++; end
    if (!(busy && !tx_start)) timeout("reach_busy");
    rst = 1'b1;
    tx_reset();
    step();
    check("mid_rst_tx_start", int'(tx_start), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ack", int'(ack), 0);
    check("mid_rst_gid", int'(grant_id), 0);
    rst = 1'b0;
    req = 4'b1111;
    wait_ack("after_rst_ack", 20);
    check("after_rst_winner", int'(ack), 4'b0001);
    req = '0;
    wait_idle("after_rst_idle", 100);

    // Random traffic with occasional reset.
    for (int c = 0; c < 4000; c++) begin
      step();
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        tx_reset();
      end else begin
        rst = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
          req_data[8*i +: 8] = 8'($urandom);
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_data[8*i +: 8] = 8'($urandom);
            req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 63) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    rst = 1'b0;
    req = '0;
    wait_idle("final_idle", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter among N_REQ byte requesters, using round-robin arbitration.
- Captures the granted byte and drives the transmitter's start/data handshake.
- Tracks the transmitter's ready line through a synchronizer, because that line is produced in the slow tx_clk domain.
- Sits between client logic (command/response engines, debug printers) and uart_tx; runs entirely on the system clk.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, grant_id width; 2**ID_W >= N_REQ required.
- SYNC_STAGES, 2, flops in the tx_ready synchronizer (>= 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester byte request; level, held until ack.
- req_data  in  8*N_REQ  requester i byte at [8i+7:8i].
- ack  out  N_REQ  one-cycle pulse: byte of requester i captured.
- tx_start  out  1  to uart_tx start.
- tx_data  out  8  to uart_tx data; held stable for the whole transfer.
- tx_ready  in  1  from uart_tx ready; asynchronous to clk.
- grant_id  out  ID_W  index of the current/last granted requester.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - state=IDLE, tx_start=0, tx_data=8'h00, ack=0, grant_id=0, busy=0.
  - rr_ptr=N_REQ-1, so requester 0 wins first.
  - All synchronizer flops reset to 1, i.e. idle ready.
- rdy_s is tx_ready after SYNC_STAGES flops. Only rdy_s is used internally.
- IDLE: if any req bit is set and rdy_s=1, grant at this edge.
  - Winner = first set req bit searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - Register tx_data<=req_data[winner], grant_id<=winner, rr_ptr<=winner.
  - ack[winner]<=1 for exactly one cycle; tx_start<=1; next state ISSUE.
- ISSUE: hold tx_start=1 until rdy_s=0 is sampled.
  - On that edge: tx_start<=0, next state BUSY.
- BUSY: wait for rdy_s=1, then next state IDLE.
  - This window covers the transmitter's START, DATA and STOP phases.
  - Back-to-back bytes leave one IDLE cycle minimum between grants.
- tx_data is unchanged from grant until the next grant. uart_tx captures data one tx_clk after start is accepted, so this stability is mandatory.
- Acceptance latency: ack is asserted in the first cycle after the grant edge.
- Requester protocol:
  - A requester may change req_data or drop req from the cycle after ack.
  - req is ignored outside IDLE.
  - Dropping req before ack withdraws the request with no side effects.
- Simultaneous requests: exactly one grant per IDLE decision; others wait. Fairness: with all N_REQ requesting, each is granted once per N_REQ transfers.
- A single requester holding req continuously gets consecutive grants.
- rdy_s=0 while in IDLE (transmitter still finishing): no grant until rdy_s=1.
- Reset mid-transfer: returns to IDLE next edge and tx_start drops. uart_tx's own reset is the system's responsibility; the arbiter re-synchronizes via rdy_s before the next grant.
- ack is one-hot or zero at all times.

Optional Feature:
- Macro: UART_ARB_LOCK_EN.
- With the macro defined:
  - Adds input req_lock [N_REQ].
  - If the winner's req_lock bit is high at grant, that requester holds exclusive access. While locked, in IDLE only the locked requester's req is considered; rr_ptr is not advanced past it.
  - The lock is released in the first IDLE cycle in which that requester's req_lock=0.
  - Reset clears the lock.
- Without the macro: no req_lock port; pure round-robin as above.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'hA5 → ack=4'b0001 one cycle after grant; tx_data=8'hA5 and tx_start held until model ready falls; busy low after ready rises.
- All four request simultaneously from reset → grant order 0,1,2,3,0; exactly one ack per transfer; tx_data follows per-requester bytes 8'h10/8'h21/8'h32/8'h43.
- Stability: during BUSY, requester 0 changes req_data to 8'hFF after ack → tx_data stays 8'hA5 until the next grant.
- Slow ready: the model delays the ready fall by 50 clk → tx_start stays 1 for all of those cycles, with no second ack and no grant_id change.
- Reset asserted in BUSY → next cycle state=IDLE, tx_start=0, busy=0, ack=0, rr_ptr back to N_REQ-1 (requester 0 wins next).
- UART_ARB_LOCK_EN: requester 2 locks while 0 and 1 request → three consecutive grants to 2; after req_lock[2]=0 the next grant goes to 3 or wraps to 0 per round-robin.
